ram_fifo_ctrl: RTL and testbench

Controller that turns a 1-read/1-write RAM with one-cycle registered read into a first-word-fall-through FIFO with valid/ready on both sides. It sits on the initiator side of the `ram1r1w` port set. It drives write address, data and enable plus read address, and consumes the registered read data through a two-entry output queue. The result is full throughput (one push and one pop per cycle) despite the read latency. Storage lives in an external `ram1r1w` instance with the same `WIDTH`/`LG_DEPTH`; this block holds only pointers, counters and the output queue.

---
 rtl/ram_fifo_ctrl_if.sv | 34 +++
 rtl/ram_fifo_ctrl.sv | 91 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle for ram_fifo_ctrl: producer/consumer handshakes, fill level, and the RAM port set.
// Handshakes: a beat moves on a rising clk edge when valid and ready are both 1;
// valid never waits on ready, and push_data/pop_data only matter while valid is 1.
interface ram_fifo_ctrl_if #(
    parameter int WIDTH    = 32,
    parameter int LG_DEPTH = 4
);
    logic                push_valid;
    logic                push_ready;
    logic [WIDTH-1:0]    push_data;
    logic                pop_valid;
    logic                pop_ready;
    logic [WIDTH-1:0]    pop_data;
    logic [LG_DEPTH+1:0] count;
    logic                ram_wr_en;
    logic [LG_DEPTH-1:0] ram_wr_addr;
    logic [WIDTH-1:0]    ram_wr_data;
    logic [LG_DEPTH-1:0] ram_rd_addr;
    logic [WIDTH-1:0]    ram_rd_data;

    // The controller side.
    modport slave (
        input  push_valid, push_data, pop_ready, ram_rd_data,
        output push_ready, pop_valid, pop_data, count,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );

    // Producer, consumer and RAM, seen from outside the controller.
    modport master (
        output push_valid, push_data, pop_ready, ram_rd_data,
        input  push_ready, pop_valid, pop_data, count,
               ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external 1R1W RAM with registered read.
// A two-entry output queue absorbs the read latency so push and pop can both fire every cycle.
module ram_fifo_ctrl #(
    parameter int WIDTH    = 32,
    parameter int LG_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    ram_fifo_ctrl_if.slave  bus
);
    localparam logic [LG_DEPTH:0] RAM_FULL = {1'b1, {LG_DEPTH{1'b0}}};

    logic [LG_DEPTH-1:0] wr_ptr;
    logic [LG_DEPTH-1:0] rd_ptr;
    logic [LG_DEPTH:0]   ram_cnt;
    logic                rd_inflight;
    logic [1:0]          q_cnt;
    logic [WIDTH-1:0]    q_head;
    logic [WIDTH-1:0]    q_tail;
    logic [LG_DEPTH+1:0] count_r;

    logic                push_fire;
    logic                pop_fire;
    logic                issue;
    logic [1:0]          q_left;
    logic [1:0]          q_cnt_n;
    logic [WIDTH-1:0]    q_head_n;
    logic [WIDTH-1:0]    q_tail_n;
    logic [LG_DEPTH:0]   ram_cnt_n;
    logic [LG_DEPTH+1:0] count_n;

    assign bus.push_ready  = reset_n && (ram_cnt < RAM_FULL);
    assign bus.pop_valid   = (q_cnt != 2'd0);
    assign bus.pop_data    = q_head;
    assign bus.count       = count_r;
    assign bus.ram_wr_en   = push_fire;
    assign bus.ram_wr_addr = wr_ptr;
    assign bus.ram_wr_data = bus.push_data;
    assign bus.ram_rd_addr = rd_ptr;

    assign push_fire = bus.push_valid && bus.push_ready;
    assign pop_fire  = bus.pop_valid && bus.pop_ready;

    always_comb begin
        q_left    = q_cnt - {1'b0, pop_fire};
        q_cnt_n   = q_left + {1'b0, rd_inflight};
        // Issue only when the slot it will land in is guaranteed after this cycle's pop.
        issue     = (ram_cnt != '0) && (q_cnt_n < 2'd2);
        q_head_n  = q_head;
        q_tail_n  = q_tail;
        if (pop_fire) begin
            q_head_n = q_tail;
        end
        if (rd_inflight) begin
            if (q_left == 2'd0) begin
                q_head_n = bus.ram_rd_data;
            end else begin
                q_tail_n = bus.ram_rd_data;
            end
        end
        ram_cnt_n = ram_cnt + {{LG_DEPTH{1'b0}}, push_fire} - {{LG_DEPTH{1'b0}}, issue};
        count_n   = count_r + {{(LG_DEPTH+1){1'b0}}, push_fire}
                            - {{(LG_DEPTH+1){1'b0}}, pop_fire};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_cnt     <= '0;
            rd_inflight <= 1'b0;
            q_cnt       <= 2'd0;
            q_head      <= '0;
            q_tail      <= '0;
            count_r     <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_cnt     <= ram_cnt_n;
            rd_inflight <= issue;
            q_cnt       <= q_cnt_n;
            q_head      <= q_head_n;
            q_tail      <= q_tail_n;
            count_r     <= count_n;
        end
    end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed and randomized checks of ram_fifo_ctrl against a behavioural registered-read RAM.
module tb_ram_fifo_ctrl;
    localparam int WIDTH    = 32;
    localparam int LG_DEPTH = 2;

    logic clk;
    logic reset_n;
    int   n_assert;
    int   n_fail;

    logic [WIDTH-1:0] mem [1 << LG_DEPTH];
    logic [WIDTH-1:0] exp_q [$];

    ram_fifo_ctrl_if #(.WIDTH(WIDTH), .LG_DEPTH(LG_DEPTH)) bus ();

    ram_fifo_ctrl #(.WIDTH(WIDTH), .LG_DEPTH(LG_DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Registered-read RAM: old data on a same-address read/write collision.
    always @(posedge clk) begin
        if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
        bus.ram_rd_data <= mem[bus.ram_rd_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] exp);
        bit got;
        got = 1'b0;
        bus.pop_ready = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            #1;
            if (bus.pop_valid) begin
                got = 1'b1;
                chk(tag, bus.pop_data, exp);
            end
            cyc();
        end
        chk({tag, "_timeout"}, {31'd0, got}, 32'd1);
        bus.pop_ready = 1'b0;
    endtask

    initial begin
        int accepted;
        int nxt;
        int got_n;
        bit started;

        n_assert       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_data  = 32'hDEAD;
        bus.pop_ready  = 1'b0;
        @(negedge clk);
        cyc();
        #1;
        chk("rst_pop_valid",  {31'd0, bus.pop_valid},  32'd0);
        chk("rst_push_ready", {31'd0, bus.push_ready}, 32'd0);
        chk("rst_wr_en",      {31'd0, bus.ram_wr_en},  32'd0);
        chk("rst_count",      {28'd0, bus.count},      32'd0);
        bus.push_valid = 1'b0;
        reset_n        = 1'b1;
        cyc();

        // Single push: pop_valid three cycles later.
        #1;
        chk("idle_push_ready", {31'd0, bus.push_ready}, 32'd1);
        bus.push_valid = 1'b1;
        bus.push_data  = 32'hA0;
        #1;
        chk("lat_wr_en",   {31'd0, bus.ram_wr_en},   32'd1);
        chk("lat_wr_addr", {30'd0, bus.ram_wr_addr}, 32'd0);
        chk("lat_wr_data", bus.ram_wr_data,          32'hA0);
        cyc();
        bus.push_valid = 1'b0;
        #1;
        chk("lat_t1_valid", {31'd0, bus.pop_valid}, 32'd0);
        chk("lat_t1_count", {28'd0, bus.count},     32'd1);
        cyc();
        #1;
        chk("lat_t2_valid", {31'd0, bus.pop_valid}, 32'd0);
        cyc();
        #1;
        chk("lat_t3_valid", {31'd0, bus.pop_valid}, 32'd1);
        chk("lat_t3_data",  bus.pop_data,           32'hA0);
        bus.pop_ready = 1'b1;
        cyc();
        bus.pop_ready = 1'b0;
        #1;
        chk("lat_after_count", {28'd0, bus.count},     32'd0);
        chk("lat_after_valid", {31'd0, bus.pop_valid}, 32'd0);
        cyc();

        // Fill past capacity with the consumer stalled, then drain in order.
        accepted = 0;
        for (int i = 1; i <= 8; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = i;
            #1;
            if (bus.push_ready) accepted++;
            cyc();
        end
        bus.push_valid = 1'b0;
        #1;
        chk("fill_accepted",   accepted,                32'd6);
        chk("fill_push_ready", {31'd0, bus.push_ready}, 32'd0);
        chk("fill_count",      {28'd0, bus.count},      32'd6);
        bus.pop_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            #1;
            chk("drain_valid", {31'd0, bus.pop_valid}, 32'd1);
            chk("drain_data",  bus.pop_data,           i);
            cyc();
        end
        bus.pop_ready = 1'b0;
        #1;
        chk("drain_empty_valid", {31'd0, bus.pop_valid}, 32'd0);
        chk("drain_empty_count", {28'd0, bus.count},     32'd0);
        cyc();

        // Streaming: once the first word appears there must be no bubbles.
        nxt     = 0;
        got_n   = 0;
        started = 1'b0;
        bus.pop_ready = 1'b1;
        for (int c = 0; c < 300 && got_n < 100; c++) begin
            bus.push_valid = (nxt < 100);
            bus.push_data  = 32'h100 + nxt;
            #1;
            if (nxt < 100) chk("stream_ready", {31'd0, bus.push_ready}, 32'd1);
            if (started)   chk("stream_gap",   {31'd0, bus.pop_valid},  32'd1);
            if (bus.pop_valid) begin
                started = 1'b1;
                chk("stream_data", bus.pop_data, 32'h100 + got_n);
                got_n++;
            end
            if (bus.push_valid && bus.push_ready) nxt++;
            cyc();
        end
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        chk("stream_done", got_n, 32'd100);
        #1;
        chk("stream_count", {28'd0, bus.count}, 32'd0);
        cyc();

        // Reset while a read is in flight.
        for (int i = 0; i < 4; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 32'h20 + i;
            cyc();
        end
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b1;
        #1;
        chk("rstmid_pop_data", bus.pop_data, 32'h20);
        cyc();
        bus.pop_ready = 1'b0;
        reset_n       = 1'b0;
        cyc();
        reset_n = 1'b1;
        #1;
        chk("rstmid_valid",      {31'd0, bus.pop_valid},  32'd0);
        chk("rstmid_count",      {28'd0, bus.count},      32'd0);
        chk("rstmid_push_ready", {31'd0, bus.push_ready}, 32'd1);
        cyc();
        #1;
        chk("rstmid_no_stale", {31'd0, bus.pop_valid}, 32'd0);
        bus.push_valid = 1'b1;
        bus.push_data  = 32'hBEEF;
        cyc();
        bus.push_valid = 1'b0;
        pop_expect("rstmid_beef", 32'hBEEF);
        #1;
        chk("rstmid_final_count", {28'd0, bus.count},     32'd0);
        chk("rstmid_final_valid", {31'd0, bus.pop_valid}, 32'd0);
        cyc();

        // Push and pop together at full: pop fires, push waits one cycle.
        for (int i = 0; i < 6; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 32'h10 + i;
            #1;
            chk("full_fill_ready", {31'd0, bus.push_ready}, 32'd1);
            cyc();
        end
        bus.push_data = 32'h16;
        bus.pop_ready = 1'b1;
        #1;
        chk("full_count",      {28'd0, bus.count},      32'd6);
        chk("full_push_ready", {31'd0, bus.push_ready}, 32'd0);
        chk("full_pop_valid",  {31'd0, bus.pop_valid},  32'd1);
        chk("full_pop_data",   bus.pop_data,            32'h10);
        cyc();
        #1;
        chk("full_next_ready", {31'd0, bus.push_ready}, 32'd1);
        chk("full_next_data",  bus.pop_data,            32'h11);
        chk("full_next_count", {28'd0, bus.count},      32'd5);
        cyc();
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        #1;
        chk("full_both_count", {28'd0, bus.count}, 32'd5);
        for (int i = 2; i <= 6; i++) begin
            pop_expect("full_drain", 32'h10 + i);
        end
        #1;
        chk("full_drain_count", {28'd0, bus.count}, 32'd0);
        cyc();

        // Random traffic against the scoreboard.
        for (int c = 0; c < 2000; c++) begin
            bus.push_valid = 1'($urandom_range(0, 1));
            bus.push_data  = $urandom;
            bus.pop_ready  = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_count", {28'd0, bus.count}, exp_q.size());
            if (bus.pop_valid && bus.pop_ready) begin
                chk("rnd_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) chk("rnd_data", bus.pop_data, exp_q.pop_front());
            end
            if (bus.push_valid && bus.push_ready) exp_q.push_back(bus.push_data);
            cyc();
        end
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) begin
            #1;
            if (bus.pop_valid) chk("rnd_drain_data", bus.pop_data, exp_q.pop_front());
            cyc();
        end
        bus.pop_ready = 1'b0;
        #1;
        chk("rnd_drain_left",  exp_q.size(),        32'd0);
        chk("rnd_drain_count", {28'd0, bus.count},  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
